// File: rtl/i2s_adc_receiver.sv
// I2S ADC receiver: samples ADCLRCK/ADCDAT on rising BCLK, assembles
// MSB-first words after the one-bit I2S delay slot, emits one sample plus
// a single-cycle valid per selected channel slot, and counts short frames.
module i2s_adc_receiver #(
  parameter int DATA_W = 16,
  parameter int CH_SEL = 0    // 0 = left only, 1 = right only, 2 = both
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_enable,
  input  logic              i_adclrck,
  input  logic              i_adcdat,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_channel,
  output logic [7:0]        o_err_cnt,
  output logic [1:0]        o_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SYNC  = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_HOLD  = 2'd3;

  localparam int CNT_W = $clog2(DATA_W + 1);

  logic              r_lrck_d;
  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [DATA_W-1:0] r_shift;
  logic [DATA_W-1:0] r_data;
  logic              r_valid;
  logic              r_channel;
  logic [7:0]        r_err_cnt;

  logic w_edge;
  logic w_sel;
  logic w_last;

  // The cycle carrying an LRCK transition is the I2S delay bit; data starts
  // one cycle later. Selection is judged on the new LRCK level.
  assign w_edge = (i_adclrck != r_lrck_d);
  assign w_sel  = (CH_SEL == 2) ? 1'b1 : (i_adclrck == (CH_SEL == 1));
  assign w_last = (r_cnt == CNT_W'(DATA_W - 1));

  // LRCK history tracks the pin unconditionally (even in reset or IDLE) so
  // that leaving reset or enabling never sees a phantom edge.
  always_ff @(posedge i_clk) begin
    r_lrck_d <= i_adclrck;
  end

  // Capture FSM: sync to an LRCK edge, shift DATA_W bits, then hold until
  // the next edge. An edge inside SHIFT is a short frame: count it and
  // restart on that same edge. Disable aborts silently.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_channel <= 1'b0;
      r_err_cnt <= 8'd0;
    end else begin
      r_valid <= 1'b0;
      if (!i_enable) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_SYNC;
          S_SYNC, S_HOLD: begin
            if (w_edge) begin
              r_cnt   <= '0;
              r_state <= w_sel ? S_SHIFT : S_HOLD;
            end
          end
          S_SHIFT: begin
            if (w_edge) begin
              if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
              r_cnt   <= '0;
              r_state <= w_sel ? S_SHIFT : S_HOLD;
            end else begin
              r_shift <= {r_shift[DATA_W-2:0], i_adcdat};
              if (w_last) begin
                r_data    <= {r_shift[DATA_W-2:0], i_adcdat};
                r_channel <= r_lrck_d;
                r_valid   <= 1'b1;
                r_cnt     <= '0;
                r_state   <= S_HOLD;
              end else begin
                r_cnt <= r_cnt + CNT_W'(1);
              end
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign o_data    = r_data;
  assign o_valid   = r_valid;
  assign o_channel = r_channel;
  assign o_err_cnt = r_err_cnt;
  assign o_state   = r_state;

endmodule

// File: tb/tb_i2s_adc_receiver.sv
// Bench for i2s_adc_receiver: one left-only and one both-channel instance
// share a directed I2S stream; expected words go into per-instance queues
// and negedge monitors pop and compare data, channel and arrival cycle.
module tb_i2s_adc_receiver;

  typedef struct {
    logic [15:0] data;
    logic        ch;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, en, lrck, dat;
  logic [15:0] d0, d2;
  logic        v0, v2, c0, c2;
  logic [7:0]  e0, e2;
  logic [1:0]  s0, s2;

  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  exp_t q0[$];
  exp_t q2[$];
  exp_t it0, it2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  i2s_adc_receiver #(.DATA_W(16), .CH_SEL(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_adclrck(lrck), .i_adcdat(dat),
    .o_data(d0), .o_valid(v0), .o_channel(c0), .o_err_cnt(e0), .o_state(s0));

  i2s_adc_receiver #(.DATA_W(16), .CH_SEL(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_enable(en), .i_adclrck(lrck), .i_adcdat(dat),
    .o_data(d2), .o_valid(v2), .o_channel(c2), .o_err_cnt(e2), .o_state(s2));

  // Monitor for the left-only instance.
  always @(negedge clk) begin
    if (v0 === 1'b1) begin
      n_vec++;
      if (q0.size() == 0) begin
        n_err++;
        $display("FAIL dut0_unexpected_valid: got data=%h ch=%0d at cyc %0d, expected no pulse", d0, c0, cyc);
      end else begin
        it0 = q0.pop_front();
        if (d0 !== it0.data || c0 !== it0.ch || cyc != it0.cyc) begin
          n_err++;
          $display("FAIL dut0_word: got data=%h ch=%0d cyc=%0d, expected data=%h ch=%0d cyc=%0d",
                   d0, c0, cyc, it0.data, it0.ch, it0.cyc);
        end
      end
    end
  end

  // Monitor for the both-channel instance.
  always @(negedge clk) begin
    if (v2 === 1'b1) begin
      n_vec++;
      if (q2.size() == 0) begin
        n_err++;
        $display("FAIL dut2_unexpected_valid: got data=%h ch=%0d at cyc %0d, expected no pulse", d2, c2, cyc);
      end else begin
        it2 = q2.pop_front();
        if (d2 !== it2.data || c2 !== it2.ch || cyc != it2.cyc) begin
          n_err++;
          $display("FAIL dut2_word: got data=%h ch=%0d cyc=%0d, expected data=%h ch=%0d cyc=%0d",
                   d2, c2, cyc, it2.data, it2.ch, it2.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One LRCK slot of len cycles: delay bit, then word MSB-first, then filler.
  // x0/x2 say whether each instance is expected to deliver this word.
  task automatic slot(input logic lvl, input logic [15:0] w, input int len,
                      input bit x0, input bit x2,
                      input int en_at = -1, input int dis_at = -1, input int rst_at = -1);
    exp_t e;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      if (rst_at >= 0 && i == rst_at + 1) begin
        chk("rst_state0", 32'(s0), 32'd0);
        chk("rst_data0",  32'(d0), 32'd0);
        chk("rst_err0",   32'(e0), 32'd0);
        chk("rst_state2", 32'(s2), 32'd0);
        chk("rst_data2",  32'(d2), 32'd0);
        chk("rst_err2",   32'(e2), 32'd0);
      end
      lrck = lvl;
      if (i >= 1 && i <= 16) dat = w[16-i];
      else                   dat = i[0];
      if (i == en_at)  en = 1'b1;
      if (i == dis_at) en = 1'b0;
      if (dis_at >= 0 && i == len - 2) en = 1'b1;
      rst = (i == rst_at);
      if (i == 0) begin
        e.data = w;
        e.ch   = lvl;
        e.cyc  = cyc + 17;
        if (x0) q0.push_back(e);
        if (x2) q2.push_back(e);
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    logic lv;
    rst = 1'b1; en = 1'b0; lrck = 1'b0; dat = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data",  32'(d0), 32'd0);
    chk("reset_valid", 32'(v0), 32'd0);
    chk("reset_ch",    32'(c0), 32'd0);
    chk("reset_err",   32'(e0), 32'd0);
    chk("reset_state", 32'(s0), 32'd0);
    rst = 1'b0;

    // Enable raised mid-left-slot: that slot is skipped.
    slot(1'b1, 16'h1111, 32, 0, 0);
    slot(1'b0, 16'h2222, 32, 0, 0, 5);
    slot(1'b1, 16'h1234, 32, 0, 1);

    // Normal 32-BCLK frames.
    slot(1'b0, 16'hA5C3, 32, 1, 1);
    slot(1'b1, 16'h1234, 32, 0, 1);
    slot(1'b0, 16'hA5C3, 32, 1, 1);
    slot(1'b1, 16'h1234, 32, 0, 1);
    chk("err_clean0", 32'(e0), 32'd0);
    chk("err_clean2", 32'(e2), 32'd0);

    // Extreme values, both channels.
    slot(1'b0, 16'h8001, 32, 1, 1);
    slot(1'b1, 16'h7FFE, 32, 0, 1);

    // Short left slot (10 data bits), then full slots.
    slot(1'b0, 16'hBEEF, 11, 0, 0);
    slot(1'b1, 16'h5555, 32, 0, 1);
    slot(1'b0, 16'hFFFF, 32, 1, 1);
    chk("err_short0", 32'(e0), 32'd1);
    chk("err_short2", 32'(e2), 32'd1);

    // Reset during bit 8 of a word, then recovery.
    slot(1'b1, 16'h0F0F, 32, 0, 1);
    slot(1'b0, 16'h3C3C, 32, 0, 0, -1, -1, 8);
    slot(1'b1, 16'h6666, 32, 0, 1);
    slot(1'b0, 16'h9999, 32, 1, 1);

    // Disable mid-word: aborted without error, outputs hold.
    slot(1'b1, 16'hAAAA, 32, 0, 1);
    slot(1'b0, 16'h4321, 32, 0, 0, -1, 8);
    chk("dis_hold0", 32'(d0), 32'h9999);
    chk("dis_hold2", 32'(d2), 32'hAAAA);
    slot(1'b1, 16'h0110, 32, 0, 1);
    slot(1'b0, 16'h1001, 32, 1, 1);
    chk("err_dis0", 32'(e0), 32'd0);
    chk("err_dis2", 32'(e2), 32'd0);

    // Flood of short frames: counter saturates and stays there.
    lv = 1'b1;
    for (int k = 0; k < 600; k++) begin
      slot(lv, 16'h0000, 3, 0, 0);
      lv = ~lv;
    end
    chk("err_sat0", 32'(e0), 32'd255);
    chk("err_sat2", 32'(e2), 32'd255);
    slot(1'b1, 16'hCAFE, 32, 0, 1);
    slot(1'b0, 16'hBABE, 32, 1, 1);
    chk("err_stay0", 32'(e0), 32'd255);
    chk("err_stay2", 32'(e2), 32'd255);

    repeat (4) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 32'd0);
    chk("q2_drained", 32'(q2.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
